grey_step_sequencer: RTL and testbench
======================================

GREY_STEP_SEQUENCER -- requirements
Module: grey_step_sequencer

Interface
REQ-001 Parameter STEP_W, default 16: width of step-count field and o_stepsLeft.
REQ-002 Parameter DIV_W, default 16: width of inter-step interval field.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_cmdValid  input  1  command request; held until accepted.
REQ-006 o_cmdReady  output  1  command acceptance possible this cycle.
REQ-007 i_cmdDir  input  1  0 = forward (00->01->11->10->00), 1 = reverse (00->10->11->01->00).
REQ-008 i_cmdSteps  input  STEP_W  number of Gray steps to emit.
REQ-009 i_cmdInterval  input  DIV_W  clock cycles per step; 0 treated as 1.
REQ-010 i_abort  input  1  terminate the running command.
REQ-011 o_greyCode  output  2  current 2-bit Gray phase.
REQ-012 o_busy  output  1  high while a command is running.
REQ-013 o_done  output  1  one-cycle completion/abort pulse.
REQ-014 o_stepsLeft  output  STEP_W  steps remaining in current/last command.

Function
REQ-015 States SHALL be IDLE and RUN; o_busy SHALL equal (state == RUN).
REQ-016 o_cmdReady SHALL be high exactly when state is IDLE and i_rst is low.
REQ-017 Command SHALL be accepted on a rising edge where i_cmdValid and o_cmdReady are both high; dir, steps and interval SHALL be latched at that edge.
REQ-018 On acceptance with i_cmdSteps != 0: state -> RUN, o_stepsLeft <= i_cmdSteps, interval counter loaded so the first step occurs N edges after acceptance (N = effective interval).
REQ-019 On acceptance with i_cmdSteps == 0: state stays IDLE, o_greyCode unchanged, o_stepsLeft <= 0, o_done high for the following cycle.
REQ-020 In RUN, steps SHALL occur every N edges; each step advances o_greyCode one position in the latched direction and decrements o_stepsLeft by 1.
REQ-021 o_greyCode SHALL change by exactly one bit per step and never otherwise (except on reset); 2-bit phase wraps freely.
REQ-022 o_greyCode position SHALL persist between commands; a new command continues from the current phase.
REQ-023 On the edge applying the final step (o_stepsLeft 1 -> 0): state -> IDLE and o_done high for exactly the next cycle.
REQ-024 i_abort high in RUN at an edge: state -> IDLE, no step that edge (abort beats a coincident step), o_greyCode and o_stepsLeft hold, o_done pulses one cycle.
REQ-025 i_abort in IDLE SHALL be ignored; i_abort coincident with acceptance SHALL not cancel the command.
REQ-026 i_cmdValid during RUN SHALL be ignored (o_cmdReady low); a new command may be accepted in the same cycle o_done is high.
REQ-027 Interval counter SHALL be DIV_W bits, no overflow at maximum interval 2^DIV_W-1.

Reset
REQ-028 With i_rst high at an edge: state IDLE, o_greyCode 00, o_busy 0, o_done 0, o_stepsLeft 0, interval counter 0, latched command cleared.
REQ-029 Reset mid-RUN SHALL abandon the command with no o_done pulse; reset overrides abort and command acceptance.

Verification
REQ-030 Reset one edge, release -> o_greyCode 00, o_busy 0, o_done 0, o_stepsLeft 0, o_cmdReady 1.
REQ-031 From 00, forward, steps 4, interval 1 -> o_greyCode 01,11,10,00 on 4 consecutive edges after acceptance; o_stepsLeft 3,2,1,0; one o_done pulse; o_busy low after.
REQ-032 From 00, reverse, steps 2, interval 3 -> 10 three edges after acceptance, 11 six edges after; no change in between; o_done once.
REQ-033 Forward, steps 5, interval 2, i_abort asserted one cycle after second step -> o_greyCode 11 held, o_stepsLeft 3, o_done one pulse, o_cmdReady 1.
REQ-034 Steps 0 -> o_greyCode unchanged, o_busy never high, o_done high one cycle after acceptance.
REQ-035 i_rst asserted after 1 of 4 forward steps -> o_greyCode 00, o_busy 0, o_stepsLeft 0, no o_done pulse.

Source files
------------

// File: rtl/grey_step_sequencer.sv
// Two-phase Gray-code step sequencer.
// It accepts a command (direction, step count, inter-step interval) with a
// valid/ready handshake. It then walks a 2-bit Gray phase one position per
// interval. The phase persists between commands. A command can be aborted.
// Reset abandons any running command silently.
module grey_step_sequencer #(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmdValid,
  output logic              o_cmdReady,
  input  logic              i_cmdDir,
  input  logic [STEP_W-1:0] i_cmdSteps,
  input  logic [DIV_W-1:0]  i_cmdInterval,
  input  logic              i_abort,
  output logic [1:0]        o_greyCode,
  output logic              o_busy,
  output logic              o_done,
  output logic [STEP_W-1:0] o_stepsLeft
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          grey_reg, grey_next;
  logic [STEP_W-1:0]   steps_reg, steps_next;
  logic [DIV_W-1:0]    cnt_reg, cnt_next;
  logic [DIV_W-1:0]    interval_reg, interval_next;
  logic                dir_reg, dir_next;
  logic                done_reg, done_next;

  logic                accept;
  logic [DIV_W-1:0]    eff_interval;

  // Forward walk: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] grey_fwd(input logic [1:0] g);
    case (g)
      2'b00:   grey_fwd = 2'b01;
      2'b01:   grey_fwd = 2'b11;
      2'b11:   grey_fwd = 2'b10;
      default: grey_fwd = 2'b00;
    endcase
  endfunction

  // Reverse walk: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] grey_rev(input logic [1:0] g);
    case (g)
      2'b00:   grey_rev = 2'b10;
      2'b10:   grey_rev = 2'b11;
      2'b11:   grey_rev = 2'b01;
      default: grey_rev = 2'b00;
    endcase
  endfunction

  // Handshake and the effective interval (an interval of 0 runs as 1)
  always_comb begin
    accept       = i_cmdValid && o_cmdReady;
    eff_interval = (i_cmdInterval == '0) ? DIV_W'(1) : i_cmdInterval;
  end

  // State register: reset clears everything, including the latched command
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      grey_reg     <= 2'b00;
      steps_reg    <= '0;
      cnt_reg      <= '0;
      interval_reg <= '0;
      dir_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grey_reg     <= grey_next;
      steps_reg    <= steps_next;
      cnt_reg      <= cnt_next;
      interval_reg <= interval_next;
      dir_reg      <= dir_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic: acceptance, step timing, completion and abort
  always_comb begin
    state_next    = state_reg;
    grey_next     = grey_reg;
    steps_next    = steps_reg;
    cnt_next      = cnt_reg;
    interval_next = interval_reg;
    dir_next      = dir_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Abort is meaningless here, so it is not looked at
        if (accept) begin
          dir_next      = i_cmdDir;
          interval_next = eff_interval;
          if (i_cmdSteps != '0) begin
            state_next = RUN;
            steps_next = i_cmdSteps;
            // Counting down from N puts the first step N edges after acceptance
            cnt_next   = eff_interval;
          end else begin
            steps_next = '0;
            done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          // Abort wins over a coincident step; phase and count freeze
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (cnt_reg <= DIV_W'(1)) begin
          grey_next  = dir_reg ? grey_rev(grey_reg) : grey_fwd(grey_reg);
          steps_next = steps_reg - STEP_W'(1);
          cnt_next   = interval_reg;
          if (steps_reg == STEP_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: ready is held off during reset so no command slips in
  always_comb begin
    o_cmdReady  = (state_reg == IDLE) && !i_rst;
    o_busy      = (state_reg == RUN);
    o_done      = done_reg;
    o_greyCode  = grey_reg;
    o_stepsLeft = steps_reg;
  end

endmodule

// File: tb/tb_grey_step_sequencer.sv
// Directed testbench for grey_step_sequencer. Each scenario task drives
// stimulus and compares outputs against hand-computed values.
`timescale 1ns/1ps
module tb_grey_step_sequencer;

  localparam int STEP_W = 16;
  localparam int DIV_W  = 16;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_cmdValid;
  logic              o_cmdReady;
  logic              i_cmdDir;
  logic [STEP_W-1:0] i_cmdSteps;
  logic [DIV_W-1:0]  i_cmdInterval;
  logic              i_abort;
  logic [1:0]        o_greyCode;
  logic              o_busy;
  logic              o_done;
  logic [STEP_W-1:0] o_stepsLeft;

  int checks = 0;
  int errors = 0;

  grey_step_sequencer #(.STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
    .i_cmdDir(i_cmdDir), .i_cmdSteps(i_cmdSteps), .i_cmdInterval(i_cmdInterval),
    .i_abort(i_abort), .o_greyCode(o_greyCode), .o_busy(o_busy),
    .o_done(o_done), .o_stepsLeft(o_stepsLeft)
  );

  always #5 i_clk = ~i_clk;

  // Advance one rising edge; return 1 ns later so outputs are settled
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic dir, input int steps, input int interval);
    i_cmdValid    = 1'b1;
    i_cmdDir      = dir;
    i_cmdSteps    = STEP_W'(steps);
    i_cmdInterval = DIV_W'(interval);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_cmdValid = 1'b0; i_cmdDir = 1'b0;
    i_cmdSteps = '0; i_cmdInterval = '0; i_abort = 1'b0;
    tick();
    i_rst = 1'b0;
    #1;
    checks++; if (o_greyCode !== 2'b00) begin errors++; $display("FAIL rst_grey got %b expected 00", o_greyCode); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b expected 0", o_done); end
    checks++; if (o_stepsLeft !== '0) begin errors++; $display("FAIL rst_steps got %0d expected 0", o_stepsLeft); end
    checks++; if (o_cmdReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b expected 1", o_cmdReady); end
    $display("test_reset done");
  endtask

  task automatic test_forward();
    logic [1:0] exp_g [4];
    int dones;
    exp_g = '{2'b01, 2'b11, 2'b10, 2'b00};
    dones = 0;
    send_cmd(1'b0, 4, 1);
    tick();
    i_cmdValid = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_stepsLeft !== 16'd4) begin errors++; $display("FAIL fwd_accept busy %b steps %0d expected 1 4", o_busy, o_stepsLeft); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_done === 1'b1) dones++;
      checks++; if (o_greyCode !== exp_g[i]) begin errors++; $display("FAIL fwd_grey%0d got %b expected %b", i, o_greyCode, exp_g[i]); end
      checks++; if (o_stepsLeft !== STEP_W'(3 - i)) begin errors++; $display("FAIL fwd_steps%0d got %0d expected %0d", i, o_stepsLeft, 3 - i); end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL fwd_busy_after got %b expected 0", o_busy); end
    tick();
    if (o_done === 1'b1) dones++;
    checks++; if (dones != 1) begin errors++; $display("FAIL fwd_done_count got %0d expected 1", dones); end
    $display("test_forward done");
  endtask

  task automatic test_reverse();
    logic [1:0] exp_g [6];
    int dones;
    exp_g = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11};
    dones = 0;
    send_cmd(1'b1, 2, 3);
    tick();
    i_cmdValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done === 1'b1) dones++;
      checks++; if (o_greyCode !== exp_g[i]) begin errors++; $display("FAIL rev_grey_edge%0d got %b expected %b", i + 1, o_greyCode, exp_g[i]); end
    end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rev_done_timing got %b expected 1", o_done); end
    tick();
    if (o_done === 1'b1) dones++;
    checks++; if (dones != 1) begin errors++; $display("FAIL rev_done_count got %0d expected 1", dones); end
    $display("test_reverse done");
  endtask

  // Starts from phase 11; two steps forward then abort -> 10 then 00? No:
  // this scenario needs phase 00 first, so it is rehomed with a reset.
  task automatic test_abort();
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    send_cmd(1'b0, 5, 2);
    tick();
    i_cmdValid = 1'b0;
    tick(); tick();
    checks++; if (o_greyCode !== 2'b01) begin errors++; $display("FAIL abort_step1 got %b expected 01", o_greyCode); end
    tick(); tick();
    checks++; if (o_greyCode !== 2'b11) begin errors++; $display("FAIL abort_step2 got %b expected 11", o_greyCode); end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    #1;
    checks++; if (o_greyCode !== 2'b11) begin errors++; $display("FAIL abort_grey got %b expected 11", o_greyCode); end
    checks++; if (o_stepsLeft !== 16'd3) begin errors++; $display("FAIL abort_steps got %0d expected 3", o_stepsLeft); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL abort_done got %b expected 1", o_done); end
    checks++; if (o_cmdReady !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL abort_idle ready %b busy %b expected 1 0", o_cmdReady, o_busy); end
    tick(); tick();
    checks++; if (o_done !== 1'b0 || o_greyCode !== 2'b11) begin errors++; $display("FAIL abort_hold done %b grey %b expected 0 11", o_done, o_greyCode); end
    $display("test_abort done");
  endtask

  task automatic test_zero_steps();
    send_cmd(1'b0, 0, 5);
    tick();
    i_cmdValid = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b expected 0", o_busy); end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL zero_done got %b expected 1", o_done); end
    checks++; if (o_greyCode !== 2'b11 || o_stepsLeft !== '0) begin errors++; $display("FAIL zero_state grey %b steps %0d expected 11 0", o_greyCode, o_stepsLeft); end
    tick();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_after done %b busy %b expected 0 0", o_done, o_busy); end
    $display("test_zero_steps done");
  endtask

  // Phase 11: one forward step -> 10, then a second command accepted while
  // o_done is high (interval 0 runs as 1, abort at acceptance is ignored) -> 00
  task automatic test_back_to_back();
    i_abort = 1'b1;
    tick();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL idle_abort done %b busy %b expected 0 0", o_done, o_busy); end
    i_abort = 1'b0;
    send_cmd(1'b0, 1, 1);
    tick();
    tick();
    checks++; if (o_greyCode !== 2'b10 || o_done !== 1'b1 || o_cmdReady !== 1'b1) begin errors++; $display("FAIL b2b_first grey %b done %b ready %b expected 10 1 1", o_greyCode, o_done, o_cmdReady); end
    send_cmd(1'b0, 1, 0);
    i_abort = 1'b1;
    tick();
    i_cmdValid = 1'b0;
    i_abort = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b1 || o_stepsLeft !== 16'd1) begin errors++; $display("FAIL b2b_accept busy %b steps %0d expected 1 1", o_busy, o_stepsLeft); end
    tick();
    checks++; if (o_greyCode !== 2'b00 || o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL b2b_second grey %b done %b busy %b expected 00 1 0", o_greyCode, o_done, o_busy); end
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midrun();
    int dones;
    dones = 0;
    send_cmd(1'b0, 4, 1);
    tick();
    i_cmdValid = 1'b0;
    tick();
    checks++; if (o_greyCode !== 2'b01) begin errors++; $display("FAIL rstrun_step got %b expected 01", o_greyCode); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_cmdReady !== 1'b0) begin errors++; $display("FAIL rstrun_ready got %b expected 0", o_cmdReady); end
    tick();
    i_rst = 1'b0;
    #1;
    if (o_done === 1'b1) dones++;
    checks++; if (o_greyCode !== 2'b00 || o_busy !== 1'b0 || o_stepsLeft !== '0) begin errors++; $display("FAIL rstrun_state grey %b busy %b steps %0d expected 00 0 0", o_greyCode, o_busy, o_stepsLeft); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_done === 1'b1) dones++;
    end
    checks++; if (dones != 0 || o_greyCode !== 2'b00) begin errors++; $display("FAIL rstrun_nodone dones %0d grey %b expected 0 00", dones, o_greyCode); end
    $display("test_reset_midrun done");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_abort();
    test_zero_steps();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
